// File: rtl/charge_station_ctrl_pkg.sv
// Shared types and helpers for the charge station controller: entry FSM states,
// display blank code and the keypad priority encoder.
package charge_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ENTRY = 1'b1
    } state_e;

    typedef enum logic [2:0] {
        KEY_NONE  = 3'd0,
        KEY_CLEAR = 3'd1,
        KEY_ENTER = 3'd2,
        KEY_START = 3'd3,
        KEY_DIGIT = 3'd4
    } key_e;

    localparam logic [7:0] BLANK = 8'hFF;

    // Resolve simultaneous keys of one strobe: clear > enter > start > digit.
    function automatic key_e key_decode(input logic clr, input logic ent,
                                        input logic st, input logic dig);
        key_e k;
        if (clr) begin
            k = KEY_CLEAR;
        end else if (ent) begin
            k = KEY_ENTER;
        end else if (st) begin
            k = KEY_START;
        end else if (dig) begin
            k = KEY_DIGIT;
        end else begin
            k = KEY_NONE;
        end
        return k;
    endfunction

endpackage

// File: rtl/charge_station_ctrl_channel.sv
// One charging port: 8-bit minute countdown with load/top-up, shared tick,
// relay enable and a one-cycle done pulse when the countdown expires.
module charge_channel
    import charge_pkg::*;
#(
    parameter logic [7:0] CAP = 8'd40
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       tick,
    input  logic [7:0] add,
    output logic       busy,
    output logic [7:0] rem,
    output logic       done
);

    logic [7:0] rem_q, rem_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [8:0] sum_s;

    // Next remaining time: a load (fresh or top-up) takes precedence over a tick.
    always_comb begin
        sum_s  = {1'b0, rem_q} + {1'b0, add};
        rem_d  = rem_q;
        done_d = 1'b0;
        if (load) begin
            rem_d = (sum_s > {1'b0, CAP}) ? CAP : sum_s[7:0];
        end else if (tick && (rem_q != 8'd0)) begin
            rem_d  = rem_q - 8'd1;
            done_d = (rem_q == 8'd1);
        end else begin
            rem_d = rem_q;
        end
        busy_d = (rem_d != 8'd0);
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= 8'd0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign rem  = rem_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: rtl/charge_station_ctrl.sv
// Paid phone-charging controller: keypad amount entry with idle timeout, shared
// minute prescaler and CHANNELS independent countdown channels.
module charge_station_ctrl
    import charge_pkg::*;
#(
    parameter int CHANNELS     = 2,
    parameter int DIGITS       = 2,
    parameter int MAX_MONEY    = 20,
    parameter int RATE         = 2,
    parameter int TICK_DIV     = 25000,
    parameter int IDLE_TIMEOUT = 250000,
    localparam int CSW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  start_set,
    input  logic                  key_start,
    input  logic                  key_clear,
    input  logic                  key_enter,
    input  logic [4:0]            key_num,
    input  logic [CSW-1:0]        ch_sel,
    output logic [7:0]            disp_money,
    output logic [7:0]            disp_time,
    output logic [CHANNELS-1:0]   ch_busy,
    output logic [CHANNELS*8-1:0] ch_rem,
    output logic [CHANNELS-1:0]   ch_done
);

    localparam int          PW    = $clog2(TICK_DIV);
    localparam int          IW    = $clog2(IDLE_TIMEOUT);
    localparam logic [15:0] MOD_W = 16'(10 ** DIGITS);
    localparam logic [7:0]  CAP   = 8'(MAX_MONEY * RATE);

    state_e            state_q, state_d;
    logic [7:0]        money_q, money_d;
    logic              set_d_q;
    logic [PW-1:0]     presc_q, presc_d;
    logic [IW-1:0]     idle_q, idle_d;
    logic [7:0]        disp_money_q, disp_money_d;
    logic [7:0]        disp_time_q, disp_time_d;

    logic              ev_s;
    logic              tick_s;
    key_e              key_s;
    logic [15:0]       prod_s;
    logic [15:0]       t_s;
    logic [7:0]        money_dig_s;
    logic [7:0]        money_time_s;
    logic [31:0]       sel_ext_s;
    logic              enter_ok_s;
    logic [CHANNELS-1:0] load_s;

    // Key event decode, prescaler tick and the entry FSM next state.
    always_comb begin
        ev_s         = start_set & ~set_d_q;
        key_s        = key_decode(ev_s & key_clear, ev_s & key_enter,
                                  ev_s & key_start, ev_s & (key_num < 5'd10));
        tick_s       = (presc_q == PW'(TICK_DIV - 1));
        presc_d      = tick_s ? '0 : presc_q + PW'(1);
        prod_s       = {8'd0, money_q} * 16'd10 + {11'd0, key_num};
        t_s          = prod_s % MOD_W;
        money_dig_s  = (t_s > 16'(MAX_MONEY)) ? 8'(MAX_MONEY) : t_s[7:0];
        money_time_s = money_q * 8'(RATE);
        sel_ext_s    = 32'(ch_sel);
        enter_ok_s   = (state_q == ENTRY) && (key_s == KEY_ENTER) &&
                       (money_q != 8'd0) && (sel_ext_s < 32'(CHANNELS));
        for (int i = 0; i < CHANNELS; i++) begin
            load_s[i] = enter_ok_s && (sel_ext_s == 32'(i));
        end

        state_d = state_q;
        money_d = money_q;
        idle_d  = idle_q;
        case (state_q)
            IDLE: begin
                money_d = 8'd0;
                idle_d  = '0;
                if (key_s == KEY_START) begin
                    state_d = ENTRY;
                end else begin
                    state_d = IDLE;
                end
            end
            ENTRY: begin
                case (key_s)
                    KEY_CLEAR: begin
                        money_d = 8'd0;
                        idle_d  = '0;
                    end
                    KEY_ENTER: begin
                        money_d = enter_ok_s ? 8'd0 : money_q;
                        idle_d  = '0;
                    end
                    KEY_START: idle_d = '0;
                    KEY_DIGIT: begin
                        money_d = money_dig_s;
                        idle_d  = '0;
                    end
                    default: begin
                        if (idle_q == IW'(IDLE_TIMEOUT - 1)) begin
                            state_d = IDLE;
                            money_d = 8'd0;
                            idle_d  = '0;
                        end else begin
                            idle_d = idle_q + IW'(1);
                        end
                    end
                endcase
            end
            default: begin
                state_d = IDLE;
                money_d = 8'd0;
                idle_d  = '0;
            end
        endcase

        disp_money_d = (state_q == ENTRY) ? money_q : BLANK;
        disp_time_d  = (state_q == ENTRY) ? money_time_s : BLANK;
    end

    // Controller registers; strobe history resets high so a held strobe is not an event.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= IDLE;
            money_q      <= 8'd0;
            set_d_q      <= 1'b1;
            presc_q      <= '0;
            idle_q       <= '0;
            disp_money_q <= BLANK;
            disp_time_q  <= BLANK;
        end else begin
            state_q      <= state_d;
            money_q      <= money_d;
            set_d_q      <= start_set;
            presc_q      <= presc_d;
            idle_q       <= idle_d;
            disp_money_q <= disp_money_d;
            disp_time_q  <= disp_time_d;
        end
    end

    assign disp_money = disp_money_q;
    assign disp_time  = disp_time_q;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        charge_channel #(
            .CAP(CAP)
        ) u_ch (
            .clk  (CLK),
            .rst_n(RST_N),
            .load (load_s[i]),
            .tick (tick_s),
            .add  (money_time_s),
            .busy (ch_busy[i]),
            .rem  (ch_rem[i*8 +: 8]),
            .done (ch_done[i])
        );
    end

endmodule

// File: tb/tb_charge_station_ctrl.sv
// Directed scenarios plus random keypad traffic, compared every cycle against an
// integer reference model of the charge station rules.
module tb_charge_station_ctrl;

    localparam int CH   = 2;
    localparam int TD   = 4;
    localparam int TO   = 20;
    localparam int RATE = 2;
    localparam int MAXM = 20;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          start_set, key_start, key_clear, key_enter;
    logic [4:0]    key_num;
    logic [0:0]    ch_sel;
    logic [7:0]    disp_money, disp_time;
    logic [CH-1:0] ch_busy, ch_done;
    logic [CH*8-1:0] ch_rem;

    int checks = 0;
    int errors = 0;

    bit m_entry, m_prev;
    int m_money, m_presc, m_idle, m_dm, m_dt;
    int m_rem[CH];
    int m_done[CH];

    charge_station_ctrl #(
        .CHANNELS(CH), .DIGITS(2), .MAX_MONEY(MAXM), .RATE(RATE),
        .TICK_DIV(TD), .IDLE_TIMEOUT(TO)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .start_set(start_set), .key_start(key_start),
        .key_clear(key_clear), .key_enter(key_enter), .key_num(key_num),
        .ch_sel(ch_sel), .disp_money(disp_money), .disp_time(disp_time),
        .ch_busy(ch_busy), .ch_rem(ch_rem), .ch_done(ch_done)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_entry = 1'b0; m_prev = 1'b1; m_money = 0; m_presc = 0; m_idle = 0;
        m_dm = 255; m_dt = 255;
        for (int c = 0; c < CH; c++) begin
            m_rem[c] = 0; m_done[c] = 0;
        end
    endtask

    // Reference: what one rising clock edge does given the current inputs.
    task automatic model_step();
        bit ev, tick;
        int load_ch, amt, t;
        ev      = start_set && !m_prev;
        m_prev  = start_set;
        tick    = (m_presc == TD - 1);
        m_presc = (m_presc + 1) % TD;
        m_dm    = m_entry ? m_money : 255;
        m_dt    = m_entry ? m_money * RATE : 255;
        load_ch = -1;
        amt     = 0;
        if (!m_entry) begin
            if (ev && key_start && !key_clear && !key_enter) begin
                m_entry = 1'b1; m_money = 0; m_idle = 0;
            end
        end else if (ev && key_clear) begin
            m_money = 0; m_idle = 0;
        end else if (ev && key_enter) begin
            if (m_money > 0 && int'(ch_sel) < CH) begin
                load_ch = int'(ch_sel); amt = m_money * RATE; m_money = 0;
            end
            m_idle = 0;
        end else if (ev && key_start) begin
            m_idle = 0;
        end else if (ev && key_num < 5'd10) begin
            t = (m_money * 10 + int'(key_num)) % 100;
            m_money = (t > MAXM) ? MAXM : t;
            m_idle = 0;
        end else if (m_idle == TO - 1) begin
            m_entry = 1'b0; m_money = 0; m_idle = 0;
        end else begin
            m_idle++;
        end
        for (int c = 0; c < CH; c++) begin
            m_done[c] = 0;
            if (c == load_ch) begin
                m_rem[c] = (m_rem[c] + amt > MAXM * RATE) ? MAXM * RATE : m_rem[c] + amt;
            end else if (tick && m_rem[c] > 0) begin
                m_rem[c]--;
                if (m_rem[c] == 0) m_done[c] = 1;
            end
        end
    endtask

    task automatic compare();
        for (int c = 0; c < CH; c++) begin
            chk($sformatf("rem%0d", c), 32'(ch_rem[c*8 +: 8]), 32'(m_rem[c]));
            chk($sformatf("busy%0d", c), 32'(ch_busy[c]), 32'(m_rem[c] > 0));
            chk($sformatf("done%0d", c), 32'(ch_done[c]), 32'(m_done[c]));
        end
        chk("disp_money", 32'(disp_money), 32'(m_dm));
        chk("disp_time", 32'(disp_time), 32'(m_dt));
    endtask

    task automatic cycle();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
        compare();
    endtask

    task automatic idle_inputs();
        start_set = 1'b0; key_start = 1'b0; key_clear = 1'b0; key_enter = 1'b0;
        key_num = 5'd31;
    endtask

    task automatic press(input bit clr, input bit ent, input bit st,
                         input int num, input int sel);
        start_set = 1'b1; key_clear = clr; key_enter = ent; key_start = st;
        key_num = 5'(num); ch_sel = 1'(sel);
        cycle();
        idle_inputs();
        cycle();
    endtask

    task automatic apply_reset();
        RST_N = 1'b0;
        model_reset();
        #1;
        compare();
        chk("rst_busy", 32'(ch_busy), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    // Advance until the model predicts the given prescaler phase at the next edge.
    task automatic align(input int phase);
        for (int i = 0; i < 2 * TD && m_presc != phase; i++) cycle();
        chk("align", 32'(m_presc), 32'(phase));
    endtask

    initial begin
        int pulses;
        idle_inputs();
        ch_sel    = 1'b0;
        start_set = 1'b1;
        key_start = 1'b1;
        RST_N     = 1'b0;
        model_reset();
        @(negedge CLK);
        compare();
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (3) cycle();
        chk("held_start", 32'(disp_money), 32'hFF);
        idle_inputs();
        cycle();
        press(0, 0, 0, 5, 0);
        press(0, 1, 0, 10, 1);
        press(1, 0, 0, 31, 0);
        chk("idle_keys", 32'(disp_time), 32'hFF);

        press(0, 0, 1, 31, 0);
        press(0, 0, 0, 1, 0);
        press(0, 0, 0, 5, 0);
        cycle();
        chk("s2_money15", 32'(disp_money), 32'd15);
        chk("s2_time30", 32'(disp_time), 32'd30);
        press(0, 0, 0, 7, 0);
        chk("s2_sat_money", 32'(disp_money), 32'd20);
        chk("s2_sat_time", 32'(disp_time), 32'd40);
        press(1, 0, 0, 31, 0);
        chk("s2_clear", 32'(disp_money), 32'd0);

        press(0, 0, 0, 3, 0);
        align(0);
        press(0, 1, 0, 31, 1);
        chk("s3_load", 32'(ch_rem[15:8]), 32'd6);
        chk("s3_disp", 32'(disp_money), 32'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (ch_done[1]) pulses++;
        end
        chk("s3_pulses", 32'(pulses), 32'd1);
        chk("s3_idle", 32'(ch_busy[1]), 32'd0);

        press(0, 0, 1, 31, 0);
        press(0, 0, 0, 5, 0);
        press(0, 1, 0, 31, 0);
        press(0, 0, 0, 2, 0);
        press(0, 0, 0, 0, 0);
        align(0);
        press(0, 1, 0, 31, 0);
        chk("s4_cap", 32'(ch_rem[7:0]), 32'd40);
        press(0, 0, 0, 4, 0);
        align(TD - 1);
        press(0, 1, 0, 31, 1);
        chk("s4_tick_load", 32'(ch_rem[15:8]), 32'd8);

        repeat (25) cycle();
        chk("s5_blank", 32'(disp_money), 32'hFF);
        chk("s5_running", 32'(ch_busy), 32'd3);

        press(0, 0, 1, 31, 0);
        press(0, 0, 0, 3, 0);
        press(1, 1, 0, 31, 0);
        chk("s6_clr_enter", 32'(disp_money), 32'd0);
        press(0, 1, 0, 31, 1);
        repeat (2) cycle();
        apply_reset();
        repeat (3) cycle();

        for (int i = 0; i < 800; i++) begin
            start_set = 1'($urandom_range(0, 1));
            key_clear = ($urandom_range(0, 9) == 0);
            key_enter = ($urandom_range(0, 3) == 0);
            key_start = ($urandom_range(0, 5) == 0);
            key_num   = 5'($urandom_range(0, 15));
            ch_sel    = 1'($urandom_range(0, 1));
            cycle();
            if (i == 500) apply_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
